// File: rtl/div_seq_unit.sv
// Multicycle signed restoring divider: one quotient bit per clock, remainder on hi, quotient on lo.
// Optional DIVU support via `define DIV_SEQ_UNSIGNED_EN (adds the unsigned_op input).
module div_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SEQ_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DZ   = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   rem_sh, diff;

`ifdef DIV_SEQ_UNSIGNED_EN
  assign signed_op = ~unsigned_op;
`else
  assign signed_op = 1'b1;
`endif

  assign sgn_a = signed_op & dividend[WIDTH-1];
  assign sgn_b = signed_op & divisor[WIDTH-1];
  assign mag_a = sgn_a ? -dividend : dividend;
  assign mag_b = sgn_b ? -divisor  : divisor;

  // Shifted remainder is one bit wider so a full-range unsigned divisor still compares correctly;
  // a clear borrow bit in diff means rem_sh >= divisor magnitude.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dz_d   = 1'b0;
          if (divisor == '0) begin
            state_d = S_DZ;
          end else begin
            dvs_d    = mag_b;
            quo_d    = mag_a;
            rem_d    = '0;
            cnt_d    = '0;
            sign_q_d = sgn_a ^ sgn_b;
            sign_r_d = sgn_a;
            state_d  = S_RUN;
          end
        end
      end
      S_DZ: begin
        dz_d    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        lo_d    = sign_q_q ? -quo_q : quo_q;
        hi_d    = sign_r_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: transaction-level latency/arithmetic model plus directed literal checks.
module tb_div_seq_unit;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [31:0] dividend, divisor;
`ifdef DIV_SEQ_UNSIGNED_EN
  logic        unsigned_op;
`endif
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  div_seq_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
`ifdef DIV_SEQ_UNSIGNED_EN
    .unsigned_op(unsigned_op),
`endif
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference arithmetic: 64-bit division truncates toward zero, remainder follows the dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic u,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = u ? longint'({32'd0, a}) : longint'({{32{a[31]}}, a});
    sb = u ? longint'({32'd0, b}) : longint'({{32{b[31]}}, b});
    q = 32'(sa / sb);
    r = 32'(sa % sb);
  endfunction

  function automatic logic cur_uns();
`ifdef DIV_SEQ_UNSIGNED_EN
    return unsigned_op;
`else
    return 1'b0;
`endif
  endfunction

  // Model: an accepted op finishes 33 edges later (1 edge for divide by zero).
  int          m_left;
  logic        m_busy, m_done, m_dz, p_dz;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clock) begin
    if (reset) begin
      m_left = 0; m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_busy = 0;
          if (p_dz) m_dz = 1;
          else begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else if (start) begin
        m_busy = 1;
        m_dz   = 0;
        if (divisor == 32'd0) begin
          p_dz = 1; m_left = 1;
        end else begin
          p_dz = 0; m_left = 33;
          ref_div(dividend, divisor, cur_uns(), p_lo, p_hi);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("busy", {31'd0, busy}, {31'd0, m_busy});
      cmp("done", {31'd0, done}, {31'd0, m_done});
      cmp("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
      cmp("hi", hi, m_hi);
      cmp("lo", lo, m_lo);
    end
  end

  task automatic set_uns(input logic u);
`ifdef DIV_SEQ_UNSIGNED_EN
    unsigned_op = u;
`endif
  endtask

  // Issues one op from idle, scrambles operands after acceptance, returns negedges until done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u, output int lat);
    @(negedge clock);
    start = 1; dividend = a; divisor = b; set_uns(u);
    @(negedge clock);
    start = 0; dividend = $urandom; divisor = $urandom; set_uns(1'($urandom));
    cmp("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 100) $display("FAIL done_timeout at %0t: got no done, expected one", $time);
  endtask

  initial begin
    int lat, ndone;
    logic [31:0] ra, rb;
    reset = 1; start = 0; dividend = 0; divisor = 0; set_uns(0);
    repeat (2) @(negedge clock);
    chk_en = 1;
    @(negedge clock);
    cmp("rst_busy", {31'd0, busy}, 32'd0);
    cmp("rst_hi", hi, 32'd0);
    cmp("rst_lo", lo, 32'd0);
    reset = 0;

    run_op(32'd7, 32'd2, 0, lat);
    cmp("lat_7_2", lat, 32'd33);
    cmp("lo_7_2", lo, 32'd3);
    cmp("hi_7_2", hi, 32'd1);
    cmp("dz_7_2", {31'd0, div_zero}, 32'd0);

    run_op(32'hFFFFFFF9, 32'd2, 0, lat);
    cmp("lo_m7_2", lo, 32'hFFFFFFFD);
    cmp("hi_m7_2", hi, 32'hFFFFFFFF);

    run_op(32'h80000000, 32'hFFFFFFFF, 0, lat);
    cmp("lo_min_m1", lo, 32'h80000000);
    cmp("hi_min_m1", hi, 32'd0);

    run_op(32'd100, 32'hFFFFFFF6, 0, lat);
    cmp("lo_100_m10", lo, 32'hFFFFFFF6);
    cmp("hi_100_m10", hi, 32'd0);

    run_op(32'd7, 32'd2, 0, lat);
    run_op(32'd5, 32'd0, 0, lat);
    cmp("lat_dz", lat, 32'd1);
    cmp("dz_flag", {31'd0, div_zero}, 32'd1);
    cmp("hi_keep_dz", hi, 32'd1);
    cmp("lo_keep_dz", lo, 32'd3);
    @(negedge clock);
    start = 1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clock);
    start = 0;
    cmp("dz_cleared", {31'd0, div_zero}, 32'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
    cmp("lo_9_3", lo, 32'd3);

    // Extra start while running must be ignored.
    @(negedge clock);
    start = 1; dividend = 32'd20; divisor = 32'd3;
    @(negedge clock);
    start = 0;
    repeat (4) @(negedge clock);
    start = 1; dividend = 32'd99; divisor = 32'd0;
    @(negedge clock);
    start = 0;
    lat = 5;
    while (done !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
    cmp("lat_ignore", lat, 32'd33);
    cmp("lo_20_3", lo, 32'd6);
    cmp("hi_20_3", hi, 32'd2);
    cmp("dz_ignore", {31'd0, div_zero}, 32'd0);

    // Reset mid-operation aborts with no done.
    @(negedge clock);
    start = 1; dividend = 32'd1000; divisor = 32'd7;
    @(negedge clock);
    start = 0;
    repeat (9) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    cmp("abort_busy", {31'd0, busy}, 32'd0);
    cmp("abort_hi", hi, 32'd0);
    cmp("abort_lo", lo, 32'd0);
    ndone = 0;
    repeat (40) begin @(negedge clock); if (done === 1'b1) ndone++; end
    cmp("abort_no_done", ndone, 32'd0);

`ifdef DIV_SEQ_UNSIGNED_EN
    run_op(32'hFFFFFFFF, 32'd2, 1, lat);
    cmp("lo_divu", lo, 32'h7FFFFFFF);
    cmp("hi_divu", hi, 32'd1);
    run_op(32'hFFFFFFFF, 32'd2, 0, lat);
    cmp("lo_div_m1_2", lo, 32'd0);
    cmp("hi_div_m1_2", hi, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'h80000000;
        3, 4: rb = $urandom_range(1, 20);
        5: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_op(ra, rb, 1'($urandom), lat);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Start held high: each done cycle is followed by an immediate new acceptance.
    for (int k = 0; k < 120; k++) begin
      @(negedge clock);
      start = 1; dividend = $urandom; divisor = $urandom | 32'd1; set_uns(1'($urandom));
    end
    @(negedge clock);
    start = 0;
    repeat (40) @(negedge clock);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq_unit.md
Name: div_seq_unit

Overview:
- Multicycle signed 32-bit restoring divider for DIV.
- Sits between the A/B operand registers and the HI/LO write path.
- Operands are captured on a start pulse from the control unit. One quotient bit is produced per clock.
- Presents remainder on hi and quotient on lo, then pulses done so the control FSM can assert HIWrite/LOWrite.

Parameters:
- WIDTH, 32, operand/result width (only 32 verified)
- CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator (from A)
- divisor  input  WIDTH  denominator (from B)
- busy  output  1  high from the edge accepting start until done is asserted
- done  output  1  single-cycle result-valid pulse
- div_zero  output  1  divide-by-zero flag, feeds exception logic
- hi  output  WIDTH  remainder
- lo  output  WIDTH  quotient

Behaviour:
- Interface rule: one clock (clock); reset is synchronous and active-high (reset). Everything updates on the rising edge of clock.
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, state IDLE, counter 0.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation.

States and transitions:
- IDLE, edge N with start=1 and divisor!=0:
  - Latch |dividend| and |divisor| as unsigned magnitudes.
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the partial remainder; set counter=0, busy=1, div_zero=0; go to RUN.
- IDLE, edge N with start=1 and divisor==0:
  - Set busy=1, div_zero=0; go to DZ.
- DZ:
  - Next edge (N+1): set div_zero=1, done=1, busy=0; go to IDLE.
  - hi/lo keep their previous values.
- RUN, each edge:
  - Shift {rem, quo} left by 1.
  - If rem >= divisor magnitude: subtract it and set the quotient LSB to 1.
  - counter++.
  - At the edge where counter reaches WIDTH (edge N+32), go to FIX.
- FIX, edge N+33:
  - lo = sign_q ? -quo : quo.
  - hi = sign_r ? -rem : rem.
  - done=1, busy=0; go to IDLE.

Done and results:
- done is high for exactly one cycle: after edge N+33 (normal) or after edge N+1 (divide by zero).
- hi/lo hold their values until the next FIX. They are never cleared by start.
- div_zero stays high until the next accepted start (which clears it) or reset.

Handshake:
- start is ignored while busy=1, and also in the done cycle if the FSM is not yet in IDLE.
- Back-to-back: start held high during the done cycle is accepted on the following edge, because the FSM is then in IDLE.
- Operands need only be valid at the accepting edge.

Arithmetic:
- Truncation toward zero; remainder takes the sign of the dividend.
- -2^31 / -1 gives lo=0x80000000, hi=0. No flag; the magnitude wraps naturally.
- Negation is two's complement, modulo 2^WIDTH.

Optional Feature:
- Macro: DIV_SEQ_UNSIGNED_EN.
- Defined:
  - Adds input port unsigned_op (1 bit), placed after divisor and sampled together with start.
  - When unsigned_op=1, operands are used raw, sign_q=sign_r=0, and FIX applies no negation (DIVU).
  - Latency is unchanged.
- Not defined:
  - The port does not exist and all operations are signed.

Test Plan:
- Reset, then start with dividend=7, divisor=2 → busy=1 next cycle; done pulses after edge N+33; lo=3, hi=1, div_zero=0.
- dividend=0xFFFFFFF9 (-7), divisor=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- dividend=0x80000000, divisor=0xFFFFFFFF → lo=0x80000000, hi=0. Then dividend=100, divisor=0xFFFFFFF6 (-10) → lo=0xFFFFFFF6, hi=0.
- Divide by zero, run after a 7/2 op: dividend=5, divisor=0 → done and div_zero=1 after edge N+1; hi=1, lo=3 unchanged. The next start clears div_zero.
- Start pulse again at cycle 5 of a running op → ignored and the original result is correct. Then reset asserted at cycle 10 of a new op → busy=0, hi=lo=0, no done pulse.
- With DIV_SEQ_UNSIGNED_EN: unsigned_op=1, 0xFFFFFFFF/2 → lo=0x7FFFFFFF, hi=1. The same operands with unsigned_op=0 → lo=0, hi=0xFFFFFFFF.
